// File: rtl/nios2_oci_dct_packer.sv
// nios2_oci_dct_packer: packs trace atoms into DCT frames with valid/ready output, drop tracking and test-end flush.
// Optional NIOS2_OCI_DCT_PARITY_EN adds out_parity, the XOR of each loaded frame.
module nios2_oci_dct_packer #(
    parameter int ATOM_W = 2,
    parameter int ATOMS  = 15,
    parameter int DROP_W = 8,
    localparam int FW    = ATOM_W * ATOMS,
    localparam int CNT_W = $clog2(ATOMS + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              atom_valid,
    input  logic [ATOM_W-1:0] atom_data,
    input  logic              test_ending,
    output logic [FW-1:0]     dct_buffer,
    output logic [CNT_W-1:0]  dct_count,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FW-1:0]     out_data,
    output logic [CNT_W-1:0]  out_count,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_count,
`ifdef NIOS2_OCI_DCT_PARITY_EN
    output logic              out_parity,
`endif
    output logic              test_has_ended
);
    typedef enum logic [1:0] {RUN, FLUSH, ENDED} state_t;
    state_t state;
    logic [FW-1:0] merged, load_data;
    logic [CNT_W-1:0] load_count;
    logic take, full, can_load, run_load, flush_load, load, drop;
    always_comb begin
        merged = dct_buffer;
        merged[ATOM_W*dct_count +: ATOM_W] = atom_data;
        take = state == RUN && atom_valid;
        full = dct_count == CNT_W'(ATOMS - 1);
        can_load = !out_valid || out_ready;
        run_load = take && full && can_load;
        drop = take && full && !can_load;
        flush_load = state == FLUSH && dct_count != '0 && can_load;
        load = run_load || flush_load;
        load_data = flush_load ? dct_buffer : merged;
        load_count = flush_load ? dct_count : CNT_W'(ATOMS);
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RUN;
            dct_buffer <= '0;
            dct_count <= '0;
            out_valid <= 1'b0;
            out_data <= '0;
            out_count <= '0;
            overflow <= 1'b0;
            drop_count <= '0;
            test_has_ended <= 1'b0;
`ifdef NIOS2_OCI_DCT_PARITY_EN
            out_parity <= 1'b0;
`endif
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                out_data <= load_data;
                out_count <= load_count;
`ifdef NIOS2_OCI_DCT_PARITY_EN
                out_parity <= ^load_data;
`endif
                dct_buffer <= '0;
                dct_count <= '0;
            end else begin
                if (out_ready) out_valid <= 1'b0;
                if (take && !full) begin
                    dct_buffer <= merged;
                    dct_count <= dct_count + 1'b1;
                end
            end
            // a completing atom with a blocked output register is lost
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != '1) drop_count <= drop_count + 1'b1;
            end
            case (state)
                RUN: if (test_ending) state <= FLUSH;
                FLUSH: if (dct_count == '0 || can_load) begin
                    state <= ENDED;
                    test_has_ended <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_nios2_oci_dct_packer.sv
// tb_nios2_oci_dct_packer: directed self-checking bench for the DCT packer.
module tb_nios2_oci_dct_packer;
    logic clk = 0, reset_n = 0, atom_valid = 0, test_ending = 0, out_ready = 0;
    logic [1:0] atom_data = 0;
    logic [29:0] dct_buffer, out_data, dct_buffer_s, out_data_s;
    logic [3:0] dct_count, out_count, dct_count_s, out_count_s;
    logic out_valid, overflow, test_has_ended, out_valid_s, overflow_s, test_has_ended_s;
    logic [7:0] drop_count;
    logic [1:0] drop_count_s;
`ifdef NIOS2_OCI_DCT_PARITY_EN
    logic out_parity, out_parity_s;
`endif
    int passed = 0, total = 0;

    always #5 clk = ~clk;

    nios2_oci_dct_packer u0 (
        .clk(clk), .reset_n(reset_n), .atom_valid(atom_valid), .atom_data(atom_data),
        .test_ending(test_ending), .dct_buffer(dct_buffer), .dct_count(dct_count),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_count(out_count), .overflow(overflow), .drop_count(drop_count),
`ifdef NIOS2_OCI_DCT_PARITY_EN
        .out_parity(out_parity),
`endif
        .test_has_ended(test_has_ended));

    nios2_oci_dct_packer #(.DROP_W(2)) u1 (
        .clk(clk), .reset_n(reset_n), .atom_valid(atom_valid), .atom_data(atom_data),
        .test_ending(test_ending), .dct_buffer(dct_buffer_s), .dct_count(dct_count_s),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
        .out_count(out_count_s), .overflow(overflow_s), .drop_count(drop_count_s),
`ifdef NIOS2_OCI_DCT_PARITY_EN
        .out_parity(out_parity_s),
`endif
        .test_has_ended(test_has_ended_s));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 0;
        atom_valid = 0;
        test_ending = 0;
        tick();
        reset_n = 1;
    endtask

    task automatic push(input int n, input int start, input int fixed);
        for (int k = start; k < start + n; k++) begin
            atom_valid = 1;
            atom_data = fixed >= 0 ? 2'(fixed) : 2'(k % 4);
            tick();
        end
        atom_valid = 0;
    endtask

    initial begin
        // reset state
        tick(); tick();
        check("rst_valid", 32'(out_valid), 0);
        check("rst_count", 32'(dct_count), 0);
        check("rst_ended", 32'(test_has_ended), 0);
        check("rst_data", 32'(out_data), 0);
        reset_n = 1;
        // test 1: asynchronous reset mid-frame
        out_ready = 1;
        push(7, 0, -1);
        check("t1_count7", 32'(dct_count), 7);
        check("t1_buf", 32'(dct_buffer), 32'h24E4);
        reset_n = 0;
        #1;
        check("t1_async_count", 32'(dct_count), 0);
        check("t1_async_buf", 32'(dct_buffer), 0);
        tick();
        reset_n = 1;
        tick();
        check("t1_ended", 32'(test_has_ended), 0);
        // test 2: full frame
        push(14, 0, -1);
        check("t2_not_yet", 32'(out_valid), 0);
        check("t2_count14", 32'(dct_count), 14);
        push(1, 14, -1);
        check("t2_valid", 32'(out_valid), 1);
        check("t2_data", 32'(out_data), 32'h24E4E4E4);
        check("t2_ocount", 32'(out_count), 15);
        check("t2_count0", 32'(dct_count), 0);
        tick();
        check("t2_accept", 32'(out_valid), 0);
        // test 3: backpressure and drop
        out_ready = 0;
        push(29, 0, -1);
        check("t3_no_ovf", 32'(overflow), 0);
        push(1, 29, -1);
        check("t3_held", 32'(out_valid), 1);
        check("t3_data", 32'(out_data), 32'h24E4E4E4);
        check("t3_count14", 32'(dct_count), 14);
        check("t3_buf", 32'(dct_buffer), 32'h03939393);
        check("t3_ovf", 32'(overflow), 1);
        check("t3_drops", 32'(drop_count), 1);
        out_ready = 1;
        tick();
        check("t3_accept", 32'(out_valid), 0);
        check("t3_keep", 32'(dct_count), 14);
        check("t3_ovf_sticky", 32'(overflow), 1);
        // test 4: partial flush
        do_reset();
        out_ready = 1;
        push(5, 0, 3);
        check("t4_buf", 32'(dct_buffer), 32'h3FF);
        test_ending = 1;
        tick();
        test_ending = 0;
        check("t4_flush_valid", 32'(out_valid), 0);
        check("t4_flush_ended", 32'(test_has_ended), 0);
        tick();
        check("t4_valid", 32'(out_valid), 1);
        check("t4_ocount", 32'(out_count), 5);
        check("t4_data", 32'(out_data), 32'h3FF);
        check("t4_ended", 32'(test_has_ended), 1);
        check("t4_count0", 32'(dct_count), 0);
        push(4, 0, 3);
        check("t4_ignore", 32'(dct_count), 0);
        check("t4_done", 32'(out_valid), 0);
        check("t4_hold_ended", 32'(test_has_ended), 1);
        check("t4_no_drop", 32'(drop_count), 0);
        // test 5: empty flush
        do_reset();
        test_ending = 1;
        tick();
        test_ending = 0;
        check("t5_mid", 32'(test_has_ended), 0);
        tick();
        check("t5_ended", 32'(test_has_ended), 1);
        check("t5_no_valid", 32'(out_valid), 0);
        // test 6: drop saturation
        do_reset();
        out_ready = 0;
        push(40, 0, -1);
        check("t6_sat", 32'(drop_count_s), 3);
        check("t6_ovf", 32'(overflow_s), 1);
        check("t6_wide", 32'(drop_count), 11);
        check("t6_frame", 32'(out_data_s), 32'h24E4E4E4);
`ifdef NIOS2_OCI_DCT_PARITY_EN
        check("t6_parity", 32'(out_parity_s), 0);
`endif
        push(3, 0, -1);
        check("t6_hold", 32'(drop_count_s), 3);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
